// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator command sequencer and its divider.
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    CMD_OPERAND = 2'd0,
    CMD_OP      = 2'd1,
    CMD_EQUALS  = 2'd2,
    CMD_CLEAR   = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_code_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HAVE_A  = 3'd1,
    ST_HAVE_OP = 3'd2,
    ST_HAVE_B  = 3'd3,
    ST_EXEC    = 3'd4,
    ST_RESULT  = 3'd5
  } calc_state_e;

  // Operand slots that take the next OPERAND command as A rather than B.
  function automatic logic loadsOperandA(calc_state_e s);
    return (s == ST_IDLE) || (s == ST_HAVE_A);
  endfunction

endpackage

// File: rtl/calc_div_unit.sv
// Restoring unsigned divider producing one quotient bit per clock.
// The first bit is resolved on the start edge, so done pulses WIDTH-1 edges later.
module calc_div_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_quotient;
  logic [CNT_W-1:0] r_count;
  logic             r_active;
  logic             r_done;

  logic [WIDTH-1:0] w_curRem;
  logic [WIDTH-1:0] w_curDivisor;
  logic             w_curBit;
  logic [WIDTH:0]   w_trial;
  logic             w_qBit;
  logic [WIDTH-1:0] w_nextRem;

  // A start pulse feeds the step directly from the inputs so no cycle is spent loading.
  always_comb begin
    w_curRem     = i_start ? '0 : r_rem;
    w_curBit     = i_start ? i_dividend[WIDTH-1] : r_shift[WIDTH-1];
    w_curDivisor = i_start ? i_divisor : r_divisor;
    w_trial      = {w_curRem, w_curBit};
    w_qBit       = (w_trial >= {1'b0, w_curDivisor});
    w_nextRem    = w_qBit ? WIDTH'(w_trial - {1'b0, w_curDivisor}) : w_trial[WIDTH-1:0];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rem      <= '0;
      r_divisor  <= '0;
      r_shift    <= '0;
      r_quotient <= '0;
      r_count    <= '0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem      <= w_nextRem;
        r_divisor  <= i_divisor;
        r_shift    <= i_dividend << 1;
        r_quotient <= {{(WIDTH-1){1'b0}}, w_qBit};
        r_count    <= CNT_W'(WIDTH - 1);
        r_active   <= 1'b1;
      end else if (r_active) begin
        r_rem      <= w_nextRem;
        r_shift    <= r_shift << 1;
        r_quotient <= {r_quotient[WIDTH-2:0], w_qBit};
        r_count    <= r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quotient;

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Command-level controller: builds A-op-B from a command stream, executes it and
// hands the result downstream over a valid/ready interface.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_type,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_err,
  output logic             o_busy,
  output logic [2:0]       o_state_dbg
);

  calc_state_e      r_state;
  logic [WIDTH-1:0] r_operandA;
  logic [WIDTH-1:0] r_operandB;
  op_code_e         r_op;
  op_code_e         r_pendOp;
  logic             r_pend;
  logic             r_cmdReady;
  logic             r_resValid;
  logic [WIDTH-1:0] r_resData;
  logic             r_resErr;
  logic             r_busy;
  logic             r_divStart;

  logic             w_accept;
  cmd_type_e        w_cmdType;
  op_code_e         w_cmdOp;
  logic             w_divDone;
  logic [WIDTH-1:0] w_quotient;
  logic [2*WIDTH-1:0] w_product;
  logic             w_divByZero;
  logic             w_execDone;
  logic [WIDTH-1:0] w_aluData;
  logic             w_aluErr;

  assign w_accept  = i_cmd_valid && r_cmdReady;
  assign w_cmdType = cmd_type_e'(i_cmd_type);
  assign w_cmdOp   = op_code_e'(i_cmd_data[1:0]);

  calc_div_unit #(
    .WIDTH(WIDTH)
  ) u_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (r_divStart),
    .i_dividend (r_operandA),
    .i_divisor  (r_operandB),
    .o_done     (w_divDone),
    .o_quotient (w_quotient)
  );

  // Division by zero never starts the divider, so it finishes like the one-cycle ops.
  always_comb begin
    w_product   = (2*WIDTH)'(r_operandA) * (2*WIDTH)'(r_operandB);
    w_divByZero = (r_operandB == '0);
    w_aluData   = '0;
    w_aluErr    = 1'b0;
    w_execDone  = 1'b1;
    case (r_op)
      OP_ADD: w_aluData = r_operandA + r_operandB;
      OP_SUB: w_aluData = r_operandA - r_operandB;
      OP_MUL: begin
        w_aluData = w_product[WIDTH-1:0];
        w_aluErr  = |w_product[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        w_aluData  = w_divByZero ? '1 : w_quotient;
        w_aluErr   = w_divByZero;
        w_execDone = w_divByZero || w_divDone;
      end
      default: w_aluData = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_operandA <= '0;
      r_operandB <= '0;
      r_op       <= OP_ADD;
      r_pendOp   <= OP_ADD;
      r_pend     <= 1'b0;
      r_cmdReady <= 1'b1;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resErr   <= 1'b0;
      r_busy     <= 1'b0;
      r_divStart <= 1'b0;
    end else begin
      r_divStart <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HAVE_A, ST_HAVE_OP, ST_HAVE_B: begin
          if (w_accept) begin
            case (w_cmdType)
              CMD_CLEAR: begin
                r_operandA <= '0;
                r_operandB <= '0;
                r_op       <= OP_ADD;
                r_pendOp   <= OP_ADD;
                r_pend     <= 1'b0;
                r_state    <= ST_IDLE;
              end
              CMD_OPERAND: begin
                if (loadsOperandA(r_state)) begin
                  r_operandA <= i_cmd_data;
                  r_state    <= ST_HAVE_A;
                end else begin
                  r_operandB <= i_cmd_data;
                  r_state    <= ST_HAVE_B;
                end
              end
              CMD_OP: begin
                // An operator after B runs the pending expression and keeps the new op for the chain.
                if (r_state == ST_HAVE_B) begin
                  r_pendOp   <= w_cmdOp;
                  r_pend     <= 1'b1;
                  r_state    <= ST_EXEC;
                  r_cmdReady <= 1'b0;
                  r_busy     <= 1'b1;
                  r_divStart <= (r_op == OP_DIV) && (r_operandB != '0);
                end else begin
                  if (r_state == ST_IDLE) r_operandA <= '0;
                  r_op    <= w_cmdOp;
                  r_state <= ST_HAVE_OP;
                end
              end
              CMD_EQUALS: begin
                if (r_state == ST_HAVE_B) begin
                  r_state    <= ST_EXEC;
                  r_cmdReady <= 1'b0;
                  r_busy     <= 1'b1;
                  r_divStart <= (r_op == OP_DIV) && (r_operandB != '0);
                end
              end
              default: r_state <= r_state;
            endcase
          end
        end
        ST_EXEC: begin
          if (w_execDone) begin
            r_resValid <= 1'b1;
            r_resData  <= w_aluData;
            r_resErr   <= w_aluErr;
            r_busy     <= 1'b0;
            r_state    <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (i_res_ready) begin
            r_resValid <= 1'b0;
            r_cmdReady <= 1'b1;
            if (r_resErr) begin
              r_operandA <= '0;
              r_operandB <= '0;
              r_op       <= OP_ADD;
              r_pendOp   <= OP_ADD;
              r_pend     <= 1'b0;
              r_state    <= ST_IDLE;
            end else if (r_pend) begin
              r_operandA <= r_resData;
              r_op       <= r_pendOp;
              r_pend     <= 1'b0;
              r_state    <= ST_HAVE_OP;
            end else begin
              r_operandA <= r_resData;
              r_state    <= ST_HAVE_A;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cmdReady <= 1'b1;
          r_resValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmdReady;
  assign o_res_valid = r_resValid;
  assign o_res_data  = r_resData;
  assign o_res_err   = r_resErr;
  assign o_busy      = r_busy;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Scoreboard bench for calc_cmd_sequencer: directed scenarios plus random command streams
// checked against an expression-level calculator model.
module tb_calc_cmd_sequencer;

  localparam int W = 8;
  localparam int CMD_OPERAND = 0, CMD_OP = 1, CMD_EQUALS = 2, CMD_CLEAR = 3;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3;
  localparam int M_EMPTY = 0, M_GOT_A = 1, M_GOT_OP = 2, M_GOT_B = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmdValid = 1'b0;
  logic         cmdReady;
  logic [1:0]   cmdType = 2'd0;
  logic [W-1:0] cmdData = '0;
  logic         resValid;
  logic         resReady = 1'b1;
  logic [W-1:0] resData;
  logic         resErr;
  logic         busy;
  logic [2:0]   stateDbg;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int readyMode = 0;

  typedef struct {
    int data;
    int err;
    int edgeK;
    int lat;
  } expT;
  expT sbQ[$];

  int mA, mB, mOp, mPendOp, mPend, mStage;

  calc_cmd_sequencer #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cmd_valid (cmdValid),
    .o_cmd_ready (cmdReady),
    .i_cmd_type  (cmdType),
    .i_cmd_data  (cmdData),
    .o_res_valid (resValid),
    .i_res_ready (resReady),
    .o_res_data  (resData),
    .o_res_err   (resErr),
    .o_busy      (busy),
    .o_state_dbg (stateDbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0: resReady = 1'b1;
        1: resReady = 1'($urandom_range(0, 1));
        default: resReady = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic void modelReset();
    mA = 0; mB = 0; mOp = OP_ADD; mPendOp = OP_ADD; mPend = 0; mStage = M_EMPTY;
  endfunction

  // Computes A op B arithmetically, queues the expected result, then applies the post-handshake update.
  function automatic void modelExec(input int edgeK);
    expT e;
    int p;
    e.lat = 1;
    e.err = 0;
    e.edgeK = edgeK;
    case (mOp)
      OP_ADD: e.data = (mA + mB) % 256;
      OP_SUB: e.data = (mA - mB + 256) % 256;
      OP_MUL: begin
        p = mA * mB;
        e.data = p % 256;
        e.err = (p >= 256) ? 1 : 0;
      end
      default: begin
        if (mB == 0) begin
          e.data = 255;
          e.err = 1;
        end else begin
          e.data = mA / mB;
          e.lat = W + 1;
        end
      end
    endcase
    sbQ.push_back(e);
    if (e.err != 0) begin
      modelReset();
    end else if (mPend != 0) begin
      mA = e.data; mOp = mPendOp; mPend = 0; mStage = M_GOT_OP;
    end else begin
      mA = e.data; mStage = M_GOT_A;
    end
  endfunction

  function automatic void modelCommand(input int t, input int d, input int edgeK);
    case (t)
      CMD_CLEAR: modelReset();
      CMD_OPERAND: begin
        if (mStage == M_EMPTY || mStage == M_GOT_A) begin
          mA = d; mStage = M_GOT_A;
        end else begin
          mB = d; mStage = M_GOT_B;
        end
      end
      CMD_OP: begin
        if (mStage == M_GOT_B) begin
          mPendOp = d % 4; mPend = 1;
          modelExec(edgeK);
        end else begin
          if (mStage == M_EMPTY) mA = 0;
          mOp = d % 4; mStage = M_GOT_OP;
        end
      end
      default: begin
        if (mStage == M_GOT_B) modelExec(edgeK);
      end
    endcase
  endfunction

  task automatic applyStimulus(input int t, input int d);
    int waited = 0;
    bit got = 0;
    cmdType = 2'(t);
    cmdData = W'(d);
    cmdValid = 1'b1;
    while (!got && waited < 300) begin
      @(negedge clk);
      if (cmdReady) got = 1;
      @(posedge clk);
      #1;
      if (!got) waited++;
    end
    cmdValid = 1'b0;
    if (got) modelCommand(t, d, cyc);
    else failNow("cmd_accept_timeout");
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #3;
      if (sbQ.size() == 0 && !resValid) done = 1;
    end
    if (!done) failNow("result_drain_timeout");
  endtask

  // Monitor: pops an expectation whenever a new result appears and checks it stays put until taken.
  initial begin
    logic prevValid;
    logic [W-1:0] heldData;
    logic heldErr;
    expT cur;
    prevValid = 1'b0;
    heldData = '0;
    heldErr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevValid = 1'b0;
      end else begin
        if (resValid) begin
          if (!prevValid) begin
            if (sbQ.size() == 0) begin
              failNow("unexpected_res_valid");
            end else begin
              cur = sbQ.pop_front();
              checkOutput("res_data", 32'(resData), cur.data);
              checkOutput("res_err", 32'(resErr), cur.err);
              checkOutput("res_latency", cyc - cur.edgeK, cur.lat);
            end
          end else begin
            checkOutput("res_data_stable", 32'(resData), 32'(heldData));
            checkOutput("res_err_stable", 32'(resErr), 32'(heldErr));
          end
          checkOutput("cmd_ready_in_result", 32'(cmdReady), 0);
          heldData = resData;
          heldErr = resErr;
        end
        prevValid = resValid;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bc;
    int hi;
    int t;
    int d;
    modelReset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_res_valid", 32'(resValid), 0);
    checkOutput("reset_res_data", 32'(resData), 0);
    checkOutput("reset_res_err", 32'(resErr), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_state", 32'(stateDbg), 0);
    checkOutput("reset_cmd_ready", 32'(cmdReady), 1);
    @(posedge clk);
    #1;

    $display("[TB] 12 + 30");
    applyStimulus(CMD_OPERAND, 12);
    applyStimulus(CMD_OP, OP_ADD);
    applyStimulus(CMD_OPERAND, 30);
    applyStimulus(CMD_EQUALS, 0);
    waitIdle();

    $display("[TB] 5 - 7");
    applyStimulus(CMD_OPERAND, 5);
    applyStimulus(CMD_OP, OP_SUB);
    applyStimulus(CMD_OPERAND, 7);
    applyStimulus(CMD_EQUALS, 0);
    waitIdle();

    $display("[TB] 20 * 13 overflow");
    applyStimulus(CMD_OPERAND, 20);
    applyStimulus(CMD_OP, OP_MUL);
    applyStimulus(CMD_OPERAND, 13);
    applyStimulus(CMD_EQUALS, 0);
    waitIdle();
    checkOutput("state_after_err", 32'(stateDbg), 0);

    $display("[TB] 200 / 7 with a command held during EXEC");
    applyStimulus(CMD_OPERAND, 200);
    applyStimulus(CMD_OP, OP_DIV);
    applyStimulus(CMD_OPERAND, 7);
    applyStimulus(CMD_EQUALS, 0);
    bc = 0;
    fork
      applyStimulus(CMD_OPERAND, 99);
      begin
        for (int j = 0; j < W + 4; j++) begin
          @(negedge clk);
          if (j < 3) checkOutput("cmd_ready_in_exec", 32'(cmdReady), 0);
          if (busy) bc++;
        end
      end
    join
    checkOutput("div_busy_at_least_width", 32'(bc >= W), 1);
    waitIdle();

    $display("[TB] 9 / 0");
    applyStimulus(CMD_CLEAR, 0);
    applyStimulus(CMD_OPERAND, 9);
    applyStimulus(CMD_OP, OP_DIV);
    applyStimulus(CMD_OPERAND, 0);
    applyStimulus(CMD_EQUALS, 0);
    waitIdle();
    applyStimulus(CMD_OPERAND, 3);
    @(negedge clk);
    checkOutput("state_after_div0_operand", 32'(stateDbg), 1);
    applyStimulus(CMD_OP, OP_ADD);
    applyStimulus(CMD_OPERAND, 1);
    applyStimulus(CMD_EQUALS, 0);
    waitIdle();

    $display("[TB] chained 3 + 4 + 10 with stalled result");
    applyStimulus(CMD_CLEAR, 0);
    applyStimulus(CMD_OPERAND, 3);
    applyStimulus(CMD_OP, OP_ADD);
    applyStimulus(CMD_OPERAND, 4);
    readyMode = 2;
    applyStimulus(CMD_OP, OP_ADD);
    repeat (6) @(negedge clk);
    checkOutput("res_valid_held", 32'(resValid), 1);
    readyMode = 0;
    waitIdle();
    checkOutput("state_after_chain", 32'(stateDbg), 2);
    applyStimulus(CMD_OPERAND, 10);
    applyStimulus(CMD_EQUALS, 0);
    waitIdle();

    $display("[TB] random command stream");
    readyMode = 1;
    applyStimulus(CMD_CLEAR, 0);
    for (int i = 0; i < 250; i++) begin
      hi = $urandom_range(0, 19);
      if (hi < 8) t = CMD_OPERAND;
      else if (hi < 13) t = CMD_OP;
      else if (hi < 19) t = CMD_EQUALS;
      else t = CMD_CLEAR;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      applyStimulus(t, d);
    end
    readyMode = 0;
    waitIdle();
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("[TB] reset during divide");
    applyStimulus(CMD_CLEAR, 0);
    applyStimulus(CMD_OPERAND, 200);
    applyStimulus(CMD_OP, OP_DIV);
    applyStimulus(CMD_OPERAND, 3);
    applyStimulus(CMD_EQUALS, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset_res_valid", 32'(resValid), 0);
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_state", 32'(stateDbg), 0);
    sbQ.delete();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bc = 0;
    for (int j = 0; j < W + 8; j++) begin
      @(negedge clk);
      if (resValid) bc++;
    end
    checkOutput("no_result_after_reset", bc, 0);
    checkOutput("cmd_ready_after_reset", 32'(cmdReady), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
